char_buffer_ctrl: RTL and testbench

- Writable 16x16 text buffer (256 x 7-bit character codes) with a controller that shares one single-port memory between the VGA character-drawing path and a character writer (keyboard/UART front end).
- Display fetches have strict priority. Writer requests are serviced at an auto-advancing cursor.
- A clear engine fills the buffer with blanks after reset and on command.
- Sits where the fixed character ROM sat. It feeds character codes to the font ROM stage using the same {row[3:0], col[3:0]} addressing.

---
 rtl/char_buffer_ctrl.sv | 103 ++++++++++
 tb/tb_char_buffer_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/char_buffer_ctrl.sv
// rtl/char_buffer_ctrl.sv - shared 16x16 character buffer: display reads, cursor writer, clear engine
// Display fetches always win the single memory port; clears and writer accesses use idle cycles.
module char_buffer_ctrl #(
  parameter logic [6:0] CLEAR_CHAR = 7'h20,
  parameter logic [6:0] NL_CHAR    = 7'h0A,
  parameter logic [6:0] BS_CHAR    = 7'h08
) (
  input  logic       pclk,
  input  logic       rst_n,
  input  logic       disp_req,
  input  logic [7:0] disp_xy,
  output logic [6:0] disp_code,
  output logic       disp_valid,
  input  logic       wr_req,
  input  logic [6:0] wr_char,
  output logic       wr_ack,
  input  logic       cmd_clear,
  input  logic       cmd_home,
  output logic [7:0] cursor,
  output logic       busy
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t     state, state_nxt;
  logic [7:0] clr_addr, clr_addr_nxt;
  logic [7:0] cursor_nxt;
  logic [6:0] mem [256];
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [6:0] mem_wdata;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= CLEAR;
      clr_addr <= '0;
      cursor   <= '0;
    end else begin
      state    <= state_nxt;
      clr_addr <= clr_addr_nxt;
      cursor   <= cursor_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    clr_addr_nxt = clr_addr;
    cursor_nxt   = cursor;
    mem_we       = 1'b0;
    mem_addr     = cursor;
    mem_wdata    = wr_char;
    wr_ack       = 1'b0;
    if (!disp_req) begin
      if (state == CLEAR) begin
        mem_we       = 1'b1;
        mem_addr     = clr_addr;
        mem_wdata    = CLEAR_CHAR;
        clr_addr_nxt = clr_addr + 8'd1;
        if (clr_addr == 8'hFF) state_nxt = IDLE;
      end else if (wr_req) begin
        wr_ack = 1'b1;
        if (wr_char == NL_CHAR) begin
          cursor_nxt = {cursor[7:4] + 4'd1, 4'h0};
        end else if (wr_char == BS_CHAR) begin
          // backspace at the origin is acknowledged but has no effect
          if (cursor != 8'h00) begin
            cursor_nxt = cursor - 8'd1;
            mem_we     = 1'b1;
            mem_addr   = cursor - 8'd1;
            mem_wdata  = CLEAR_CHAR;
          end
        end else begin
          mem_we     = 1'b1;
          cursor_nxt = cursor + 8'd1;
        end
      end
    end
    if (cmd_clear) begin
      state_nxt    = CLEAR;
      clr_addr_nxt = '0;
      cursor_nxt   = '0;
    end else if (cmd_home) begin
      cursor_nxt = '0;
    end
  end

  assign busy = (state == CLEAR);

  always_ff @(posedge pclk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      disp_code  <= '0;
      disp_valid <= 1'b0;
    end else begin
      disp_valid <= disp_req;
      if (disp_req) disp_code <= mem[disp_xy];
    end
  end

endmodule

// File: tb/tb_char_buffer_ctrl.sv
// tb/tb_char_buffer_ctrl.sv - self-checking bench for char_buffer_ctrl
module tb_char_buffer_ctrl;
  logic       pclk = 1'b0, rst_n = 1'b0;
  logic       disp_req = 1'b0, wr_req = 1'b0, cmd_clear = 1'b0, cmd_home = 1'b0;
  logic [7:0] disp_xy = '0;
  logic [6:0] wr_char = '0;
  logic [6:0] disp_code;
  logic       disp_valid, wr_ack, busy;
  logic [7:0] cursor;

  int n_checks = 0;
  int n_fail   = 0;

  char_buffer_ctrl dut (
    .pclk(pclk), .rst_n(rst_n), .disp_req(disp_req), .disp_xy(disp_xy),
    .disp_code(disp_code), .disp_valid(disp_valid), .wr_req(wr_req),
    .wr_char(wr_char), .wr_ack(wr_ack), .cmd_clear(cmd_clear),
    .cmd_home(cmd_home), .cursor(cursor), .busy(busy)
  );

  always #5 pclk = ~pclk;

  logic [6:0] m_mem [256];
  int         m_cursor, m_clr_left, m_clr_pos;
  logic [6:0] m_code;
  bit         m_valid, last_ack;

  typedef struct {
    bit         dr;
    bit         wq;
    logic [6:0] ch;
    bit         home;
    bit         exp_ack;
    logic [7:0] exp_cur;
  } vec_t;
  vec_t vecs [16];

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_cursor   = 0;
    m_clr_left = 256;
    m_clr_pos  = 0;
    m_code     = '0;
    m_valid    = 1'b0;
  endtask

  // One clock cycle: drive, check mid-cycle, advance the model; entered and left at posedge+1
  task automatic cycle(bit dr, logic [7:0] xy, bit wq, logic [6:0] ch, bit clr, bit home);
    bit exp_ack;
    disp_req = dr; disp_xy = xy; wr_req = wq; wr_char = ch; cmd_clear = clr; cmd_home = home;
    #4;
    exp_ack = (m_clr_left == 0) && !dr && wq;
    check("wr_ack", int'(wr_ack), int'(exp_ack));
    check("busy", int'(busy), int'(m_clr_left != 0));
    check("cursor", int'(cursor), m_cursor);
    check("disp_valid", int'(disp_valid), int'(m_valid));
    check("disp_code", int'(disp_code), int'(m_code));
    last_ack = wr_ack;
    m_valid = dr;
    if (dr) begin
      m_code = m_mem[xy];
    end else if (m_clr_left != 0) begin
      m_mem[m_clr_pos] = 7'h20;
      m_clr_pos++;
      m_clr_left--;
    end else if (wq) begin
      if (ch == 7'h0A) m_cursor = ((m_cursor / 16 + 1) % 16) * 16;
      else if (ch == 7'h08) begin
        if (m_cursor != 0) begin
          m_cursor--;
          m_mem[m_cursor] = 7'h20;
        end
      end else begin
        m_mem[m_cursor] = ch;
        m_cursor = (m_cursor + 1) % 256;
      end
    end
    if (clr) begin
      m_clr_left = 256; m_clr_pos = 0; m_cursor = 0;
    end else if (home) m_cursor = 0;
    @(posedge pclk); #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 7'h00, 1'b0, 1'b0);
  endtask

  task automatic read_check(string name, logic [7:0] a, logic [6:0] exp);
    cycle(1'b1, a, 1'b0, 7'h00, 1'b0, 1'b0);
    check(name, int'(disp_code), int'(exp));
  endtask

  task automatic expect_blank_buffer(string name);
    int bad = 0;
    for (int a = 0; a < 256; a++) begin
      cycle(1'b1, 8'(a), 1'b0, 7'h00, 1'b0, 1'b0);
      if (disp_code !== 7'h20 || disp_valid !== 1'b1) bad++;
    end
    check(name, bad, 0);
  endtask

  task automatic count_busy(string name);
    int cnt = 0;
    for (int i = 0; i < 400 && busy; i++) begin
      cnt++;
      cycle(1'b0, 8'h00, 1'b0, 7'h00, 1'b0, 1'b0);
    end
    check(name, cnt, 256);
  endtask

  initial begin
    int nonstall, guard, pick, stalled;
    logic [6:0] ch;
    vecs = '{
      '{0, 1, 7'h41, 0, 1, 8'h01}, '{0, 1, 7'h43, 0, 1, 8'h02},
      '{0, 1, 7'h08, 0, 1, 8'h01}, '{0, 0, 7'h00, 1, 0, 8'h00},
      '{0, 1, 7'h08, 0, 1, 8'h00}, '{0, 1, 7'h0A, 0, 1, 8'h10},
      '{0, 1, 7'h0A, 0, 1, 8'h20}, '{0, 1, 7'h0A, 0, 1, 8'h30},
      '{0, 1, 7'h61, 0, 1, 8'h31}, '{0, 1, 7'h62, 0, 1, 8'h32},
      '{0, 1, 7'h63, 0, 1, 8'h33}, '{0, 1, 7'h64, 0, 1, 8'h34},
      '{0, 1, 7'h65, 0, 1, 8'h35}, '{0, 1, 7'h0A, 0, 1, 8'h40},
      '{1, 1, 7'h5A, 0, 0, 8'h40}, '{0, 1, 7'h5A, 1, 1, 8'h00}
    };
    model_reset();
    repeat (3) @(posedge pclk);
    #1;
    check("rst disp_code", int'(disp_code), 0);
    check("rst disp_valid", int'(disp_valid), 0);
    check("rst wr_ack", int'(wr_ack), 0);
    check("rst cursor", int'(cursor), 0);
    check("rst busy", int'(busy), 1);
    rst_n = 1'b1;
    count_busy("initial clear cycles");
    expect_blank_buffer("initial blank buffer");

    for (int i = 0; i < 16; i++) begin
      cycle(vecs[i].dr, 8'h00, vecs[i].wq, vecs[i].ch, 1'b0, vecs[i].home);
      check($sformatf("vec%0d ack", i), int'(last_ack), int'(vecs[i].exp_ack));
      check($sformatf("vec%0d cursor", i), int'(cursor), int'(vecs[i].exp_cur));
    end
    read_check("mem00 A", 8'h00, 7'h41);
    read_check("mem01 bs blank", 8'h01, 7'h20);
    read_check("mem30", 8'h30, 7'h61);
    read_check("mem34", 8'h34, 7'h65);
    read_check("mem35 nl untouched", 8'h35, 7'h20);
    read_check("mem40", 8'h40, 7'h5A);

    stalled = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 8'(i), 1'b1, 7'h51, 1'b0, 1'b0);
      if (last_ack) stalled++;
    end
    check("ack during display stall", stalled, 0);
    cycle(1'b0, 8'h00, 1'b1, 7'h51, 1'b0, 1'b0);
    check("ack after stall", int'(last_ack), 1);
    idle(1);

    cycle(1'b0, 8'h00, 1'b0, 7'h00, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) cycle(1'b0, 8'h00, 1'b1, 7'h0A, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) cycle(1'b0, 8'h00, 1'b1, 7'h6B, 1'b0, 1'b0);
    check("cursor F7", int'(cursor), 8'hF7);
    cycle(1'b0, 8'h00, 1'b1, 7'h0A, 1'b0, 1'b0);
    check("nl row wrap", int'(cursor), 8'h00);
    for (int i = 0; i < 15; i++) cycle(1'b0, 8'h00, 1'b1, 7'h0A, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) cycle(1'b0, 8'h00, 1'b1, 7'h6D, 1'b0, 1'b0);
    check("cursor FF", int'(cursor), 8'hFF);
    cycle(1'b0, 8'h00, 1'b1, 7'h42, 1'b0, 1'b0);
    check("char wrap", int'(cursor), 8'h00);
    read_check("memFF B", 8'hFF, 7'h42);

    cycle(1'b0, 8'h00, 1'b0, 7'h00, 1'b1, 1'b0);
    idle(128);
    cycle(1'b0, 8'h00, 1'b0, 7'h00, 1'b1, 1'b0);
    nonstall = 0;
    guard = 0;
    while (busy && guard < 1000) begin
      if (guard % 2 == 0) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0, 7'h00, 1'b0, 1'b0);
      else begin
        cycle(1'b0, 8'h00, 1'b0, 7'h00, 1'b0, 1'b0);
        nonstall++;
      end
      guard++;
    end
    check("restarted clear writes", nonstall, 256);
    expect_blank_buffer("blank after restart");

    for (int i = 0; i < 400; i++) begin
      pick = $urandom_range(0, 9);
      ch = (pick == 0) ? 7'h0A : (pick == 1) ? 7'h08 : 7'(7'h61 + $urandom_range(0, 25));
      cycle($urandom_range(0, 3) == 0, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
            ch, $urandom_range(0, 299) == 0, $urandom_range(0, 49) == 0);
    end
    for (int a = 0; a < 256; a++) cycle(1'b1, 8'(a), 1'b0, 7'h00, 1'b0, 1'b0);

    for (int i = 0; i < 400 && busy; i++) idle(1);
    check("idle before reset test", int'(busy), 0);
    cycle(1'b0, 8'h00, 1'b1, 7'h52, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b1, 7'h52, 1'b0, 1'b0);
    cycle(1'b1, 8'h00, 1'b0, 7'h00, 1'b0, 1'b0);
    disp_req = 1'b0; wr_req = 1'b1; wr_char = 7'h53;
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst wr_ack", int'(wr_ack), 0);
    check("async rst cursor", int'(cursor), 0);
    check("async rst busy", int'(busy), 1);
    check("async rst disp_valid", int'(disp_valid), 0);
    check("async rst disp_code", int'(disp_code), 0);
    wr_req = 1'b0;
    model_reset();
    @(posedge pclk);
    #1;
    rst_n = 1'b1;
    count_busy("clear after reset");
    expect_blank_buffer("blank after reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
